// File: rtl/xoodyak_pkg.sv
// Shared constants, state encoding and helpers for the Xoodyak message feeder.
package xoodyak_pkg;

  localparam int BLOCK_BYTES    = 16;
  localparam int HASH_BYTES_DEF = 32;
  localparam int MSG_LEN_W      = 12;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREFILL = 3'd1;
  localparam logic [2:0] S_START   = 3'd2;
  localparam logic [2:0] S_FEED    = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  function automatic logic [MSG_LEN_W-1:0] prefill_target(
    input logic [MSG_LEN_W-1:0] len,
    input logic [MSG_LEN_W-1:0] pre
  );
    return (len < pre) ? len : pre;
  endfunction

endpackage

// File: rtl/xoodyak_byte_fifo.sv
// Synchronous first-word-fall-through FIFO; push and pop may coincide even when full.
module xoodyak_byte_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xoodyak_msg_feeder.sv
// Buffers a length-prefixed byte stream and paces it into the Xoodyak core, then counts digest beats.
// Optional msg_count output is built when FEEDER_STATS_EN is defined.
//
// state     | meaning
// IDLE      | waiting for a message length
// PREFILL   | buffering min(len, PREFILL) bytes
// START     | core_start issued next edge
// FEED      | one byte to the core per busy-low cycle
// WAIT_HASH | counting core_valid digest beats
// DONE      | done issued next edge
module xoodyak_msg_feeder
  import xoodyak_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int PREFILL    = BLOCK_BYTES,
  parameter int HASH_BYTES = HASH_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 s_len_valid,
  input  logic [MSG_LEN_W-1:0] s_len,
  output logic                 s_len_ready,
  input  logic                 s_valid,
  input  logic [7:0]           s_data,
  output logic                 s_ready,
  output logic                 core_start,
  output logic [7:0]           core_msg,
  output logic [MSG_LEN_W-1:0] core_msg_len,
  input  logic                 core_busy,
  input  logic                 core_valid,
  output logic                 done,
  output logic                 underrun
`ifdef FEEDER_STATS_EN
  ,output logic [15:0]         msg_count
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(HASH_BYTES) + 1;

  logic [2:0]           state;
  logic                 live;
  logic [MSG_LEN_W-1:0] sent;
  logic [MSG_LEN_W-1:0] pushed;
  logic [MSG_LEN_W-1:0] target;
  logic [BW-1:0]        beats;
  logic                 len_hs;
  logic                 in_rx;
  logic                 feed_go;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_dout;
  logic [CW-1:0]        fifo_count;

  assign target      = prefill_target(core_msg_len, MSG_LEN_W'(PREFILL));
  assign s_len_ready = live && (state == S_IDLE);
  assign len_hs      = s_len_valid && s_len_ready;
  assign in_rx       = (state == S_PREFILL) || (state == S_START) || (state == S_FEED);
  assign feed_go     = (state == S_FEED) && !core_busy;
  // Bytes left over after an underrun are drained so FEED can always terminate.
  assign fifo_pop    = feed_go && !fifo_empty;
  assign s_ready     = in_rx && (pushed < core_msg_len) && (!fifo_full || fifo_pop);
  assign fifo_push   = s_valid && s_ready;

  xoodyak_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (fifo_push),
    .din    (s_data),
    .pop    (fifo_pop),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      live         <= 1'b0;
      core_msg_len <= '0;
      sent         <= '0;
      pushed       <= '0;
      beats        <= '0;
      core_start   <= 1'b0;
      core_msg     <= '0;
      done         <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      live       <= 1'b1;
      core_start <= (state == S_START);
      done       <= (state == S_DONE);
      if (fifo_push) pushed <= pushed + MSG_LEN_W'(1);
      case (state)
        S_IDLE: begin
          if (len_hs) begin
            core_msg_len <= s_len;
            sent         <= '0;
            pushed       <= '0;
            beats        <= '0;
            underrun     <= 1'b0;
            core_msg     <= '0;
            state        <= (s_len == '0) ? S_START : S_PREFILL;
          end
        end
        S_PREFILL: begin
          if (MSG_LEN_W'(fifo_count) >= target) state <= S_START;
        end
        S_START: state <= S_FEED;
        S_FEED: begin
          if (!core_busy) begin
            if (sent < core_msg_len) begin
              sent <= sent + MSG_LEN_W'(1);
              if (fifo_empty) begin
                underrun <= 1'b1;
                core_msg <= '0;
              end else begin
                core_msg <= fifo_dout;
              end
            end else begin
              core_msg <= '0;
            end
          end
          if ((sent == core_msg_len) && fifo_empty) state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_valid) begin
            beats <= beats + BW'(1);
            if (beats == BW'(HASH_BYTES - 1)) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FEEDER_STATS_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)   msg_count <= '0;
    else if (done) msg_count <= msg_count + 16'd1;
  end
`endif

endmodule
